// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory req/gnt/rvalid bus between fetch and imem
interface fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I fetch stage with single-outstanding imem port and IF/ID register
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall_f,
   input  logic          flush_d,
   input  logic          pc_src,
   input  logic [31:0]   pc_target,
   fetch_stage_if.master imem,
   output logic [31:0]   instr_d,
   output logic [31:0]   pc_d,
   output logic [31:0]   pc_plus4_d,
   output logic          valid_d
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

   state_t      state;
   logic [31:0] pc_f;
   logic [31:0] skid_word;
   logic        skid_v;
   logic        kill;
   logic [31:0] target_al;
   logic [31:0] pc_next4;

   assign target_al = pc_target & ~32'd3;
   assign pc_next4  = pc_f + 32'd4;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         pc_f           <= RESET_PC;
         kill           <= 1'b0;
         skid_v         <= 1'b0;
         skid_word      <= NOP_INSTR;
         imem.imem_req  <= 1'b0;
         imem.imem_addr <= RESET_PC;
         instr_d        <= NOP_INSTR;
         pc_d           <= 32'd0;
         pc_plus4_d     <= 32'd4;
         valid_d        <= 1'b0;
      end else begin
         // IF/ID becomes a bubble unless a stall holds it or a load below overrides
         if (pc_src || flush_d || !stall_f) begin
            instr_d <= NOP_INSTR;
            valid_d <= 1'b0;
         end
         case (state)
            IDLE: begin
               state         <= REQ;
               imem.imem_req <= 1'b1;
               if (pc_src) begin
                  pc_f           <= target_al;
                  imem.imem_addr <= target_al;
               end else begin
                  imem.imem_addr <= pc_f;
               end
            end
            REQ: begin
               // a redirect cannot cancel the presented request, so its response is killed
               if (pc_src) begin
                  pc_f <= target_al;
                  kill <= 1'b1;
               end
               if (imem.imem_gnt) begin
                  state         <= WAIT;
                  imem.imem_req <= 1'b0;
               end
            end
            WAIT: begin
               if (imem.imem_rvalid) begin
                  if (kill || pc_src) begin
                     kill          <= 1'b0;
                     state         <= REQ;
                     imem.imem_req <= 1'b1;
                     if (pc_src) begin
                        pc_f           <= target_al;
                        imem.imem_addr <= target_al;
                     end else begin
                        imem.imem_addr <= pc_f;
                     end
                  end else if (stall_f) begin
                     skid_word <= imem.imem_rdata;
                     skid_v    <= 1'b1;
                     state     <= HOLD;
                  end else begin
                     if (!flush_d) begin
                        instr_d    <= imem.imem_rdata;
                        pc_d       <= pc_f;
                        pc_plus4_d <= pc_next4;
                        valid_d    <= 1'b1;
                     end
                     pc_f           <= pc_next4;
                     imem.imem_addr <= pc_next4;
                     imem.imem_req  <= 1'b1;
                     state          <= REQ;
                  end
               end else if (pc_src) begin
                  pc_f <= target_al;
                  kill <= 1'b1;
               end
            end
            HOLD: begin
               if (pc_src) begin
                  skid_v         <= 1'b0;
                  pc_f           <= target_al;
                  imem.imem_addr <= target_al;
                  imem.imem_req  <= 1'b1;
                  state          <= REQ;
               end else if (!stall_f && skid_v) begin
                  if (!flush_d) begin
                     instr_d    <= skid_word;
                     pc_d       <= pc_f;
                     pc_plus4_d <= pc_next4;
                     valid_d    <= 1'b1;
                  end
                  skid_v         <= 1'b0;
                  pc_f           <= pc_next4;
                  imem.imem_addr <= pc_next4;
                  imem.imem_req  <= 1'b1;
                  state          <= REQ;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
